// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and line idle level.
// Used by both the transmit and receive sides.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        MARK      = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear || tick) count <= '0;
    else                      count <= count + 1'b1;
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB first, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_t          state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_idx;
  logic                 tick;
  logic                 baud_clear;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  // The counter is held at zero in IDLE and wraps on tick, so every state
  // change (accept or end of a bit period) starts a fresh period.
  assign baud_clear = (state == IDLE);

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      txd      <= MARK;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift    <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity   <= ^tx_data;
`endif
            bit_idx  <= '0;
            state    <= START;
            txd      <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            txd   <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift <= shift >> 1;
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              txd     <= parity;
`else
              state   <= STOP;
              txd     <= MARK;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            txd   <= MARK;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (bit_idx == LAST_STOP) begin
              bit_idx  <= '0;
              state    <= IDLE;
              done     <= 1'b1;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          txd      <= MARK;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard of accepted bytes checked bit-by-bit on txd.
module tb_uart_tx;

  localparam int unsigned N   = 4;
  localparam int unsigned SB  = 1;
  localparam int unsigned N2  = 2;
  localparam int unsigned SB2 = 2;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data, tx_data2;
  logic       tx_valid, tx_valid2;
  logic       tx_ready, txd, busy, done;
  logic       tx_ready2, txd2, busy2, done2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  sb[$];

  uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(SB)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd), .busy(busy), .done(done)
  );

  uart_tx #(.CLKS_PER_BIT(N2), .STOP_BITS(SB2)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .txd(txd2), .busy(busy2), .done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void build_frame(input logic [7:0] b, input int unsigned stops,
                                      output logic [15:0] bits, output int unsigned nb);
    bits    = '1;
    bits[0] = 1'b0;
    for (int unsigned i = 0; i < 8; i++) bits[1+i] = b[i];
    nb = 9;
`ifdef UART_TX_PARITY_EN
    bits[9] = ^b;
    nb = 10;
`endif
    nb = nb + stops;
  endfunction

  // Frame monitor for the main instance
  logic [15:0] mbits;
  int unsigned mnb = 0, mcyc = 0, gap = 0;
  bit          in_frame = 0, exp_done = 0, chk_gap = 0;

  always @(negedge clk) begin
    logic [7:0] b;
    if (rst) begin
      in_frame = 0;
      exp_done = 0;
    end else begin
      if (exp_done) begin
        check("done_pulse", done, 1'b1);
        check("ready_at_done", tx_ready, 1'b1);
        check("mark_at_done", txd, 1'b1);
        exp_done = 0;
        gap = 1;
      end else if (!in_frame) begin
        if (done) check("spurious_done", done, 1'b0);
        if (txd == 1'b0) begin
          if (sb.size() == 0) begin
            check("spurious_frame", txd, 1'b1);
          end else begin
            b = sb.pop_front();
            build_frame(b, SB, mbits, mnb);
            in_frame = 1;
            mcyc = 0;
            if (chk_gap) begin
              check("b2b_gap", gap, 1);
              chk_gap = 0;
            end
          end
        end else begin
          gap++;
        end
      end
      if (in_frame) begin
        check("txd_bit", txd, mbits[mcyc/N]);
        check("done_low", done, 1'b0);
        mcyc++;
        if (mcyc == mnb*N) begin
          in_frame = 0;
          exp_done = 1;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int unsigned w;
    w = 0;
    while (!tx_ready && w < 500) begin
      @(posedge clk); #2;
      w++;
    end
    check("ready_wait", tx_ready, 1'b1);
    tx_valid = 1'b1;
    tx_data  = b;
    sb.push_back(b);
    @(posedge clk); #2;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    check("start_latency", txd, 1'b0);
    check("busy_on", busy, 1'b1);
    check("ready_off", tx_ready, 1'b0);
  endtask

  task automatic wait_done();
    int unsigned w;
    w = 0;
    while (w < 2000) begin
      @(posedge clk); #2;
      if (done) break;
      w++;
    end
    check("done_seen", done, 1'b1);
  endtask

  initial begin
    logic [15:0] bits2;
    int unsigned nb2, dc;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_valid2 = 1'b0; tx_data2 = '0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("rst_txd", txd, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #2; end

    // Single bytes, including parity polarities
    send(8'hA5);
    wait_done();
    check("idle_ready", tx_ready, 1'b1);
    check("idle_busy", busy, 1'b0);
    repeat (5) begin @(posedge clk); #2; end
    send(8'h01);
    wait_done();
    repeat (5) begin @(posedge clk); #2; end

    // Back-to-back with tx_valid held high
    tx_valid = 1'b1; tx_data = 8'h3C; sb.push_back(8'h3C);
    @(posedge clk); #2;
    tx_data = 8'hC3; sb.push_back(8'hC3);
    wait_done();
    chk_gap = 1;
    @(posedge clk); #2;
    tx_valid = 1'b0;
    check("b2b_accept", busy, 1'b1);
    wait_done();
    repeat (5) begin @(posedge clk); #2; end

    // Offer while busy must be ignored
    send(8'h00);
    repeat (10) begin @(posedge clk); #2; end
    tx_valid = 1'b1; tx_data = 8'hFF;
    @(posedge clk); #2;
    tx_valid = 1'b0;
    check("ignore_busy", busy, 1'b1);
    wait_done();
    repeat (60) begin @(posedge clk); #2; end
    check("ignore_sb_empty", sb.size(), 0);

    // Reset during DATA bit 3, with tx_valid offered in the reset cycle
    send(8'hB4);
    repeat (16) begin @(posedge clk); #2; end
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h77;
    @(posedge clk); #2;
    rst = 1'b0; tx_valid = 1'b0;
    check("midrst_txd", txd, 1'b1);
    check("midrst_ready", tx_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    dc = 0;
    repeat (60) begin
      @(posedge clk); #2;
      if (done) dc++;
    end
    check("no_done_after_rst", dc, 0);
    check("rst_valid_ignored", busy, 1'b0);
    send(8'h5A);
    wait_done();
    repeat (5) begin @(posedge clk); #2; end

    // Two stop bits, two clocks per bit
    build_frame(8'h80, SB2, bits2, nb2);
    tx_valid2 = 1'b1; tx_data2 = 8'h80;
    @(posedge clk); #2;
    tx_valid2 = 1'b0; tx_data2 = 8'h00;
    check("d2_busy", busy2, 1'b1);
    for (int unsigned i = 0; i < nb2*N2; i++) begin
      check("d2_txd", txd2, bits2[i/N2]);
      check("d2_done_low", done2, 1'b0);
      @(posedge clk); #2;
    end
    check("d2_done", done2, 1'b1);
    check("d2_ready", tx_ready2, 1'b1);
    check("d2_mark", txd2, 1'b1);
    @(posedge clk); #2;
    check("d2_done_once", done2, 1'b0);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tx_data  input  8  byte to transmit; sampled only on an accept edge.
REQ-006 tx_valid  input  1  byte-offer strobe from the producer.
REQ-007 tx_ready  output  1  high when the block can accept a byte.
REQ-008 txd  output  1  serial line; mark (idle) = 1.
REQ-009 busy  output  1  high while a frame is in progress.
REQ-010 done  output  1  one-cycle pulse when a frame completes.

Function
REQ-011 The FSM shall have states IDLE, START, DATA, PARITY, STOP; encoding is defined in the package.
REQ-012 Accept = tx_valid && tx_ready at a posedge.
- tx_data latches into an 8-bit shift register.
- The FSM moves IDLE->START.
REQ-013 tx_ready shall be 1 only in IDLE; busy shall be the exact complement of tx_ready.
REQ-014 txd shall be registered:
- 1 in IDLE and STOP.
- 0 in START.
- The current shift[0] in DATA.
- The parity bit in PARITY.
REQ-015 Each of START, each DATA bit, PARITY, and each stop bit shall last exactly CLKS_PER_BIT cycles.
- Timing comes from a baud counter that counts 0..CLKS_PER_BIT-1.
- The counter clears on every state change.
REQ-016 Data shall be sent LSB first.
- Shift right by one at the end of each DATA bit period.
- A 3-bit bit index counts 0..7; DATA exits after index 7.
REQ-017 Transitions:
- START->DATA.
- DATA->PARITY when PARITY_EN is defined, otherwise DATA->STOP.
- PARITY->STOP.
- STOP->IDLE after STOP_BITS*CLKS_PER_BIT cycles.
REQ-018 done shall pulse high for exactly the one cycle in which the FSM enters IDLE from STOP.
REQ-019 In that first IDLE cycle tx_ready=1, so back-to-back frames shall be separated by exactly one mark cycle.
REQ-020 Latency: the start bit appears on txd on the posedge immediately after the accept edge.
REQ-021 tx_valid asserted while busy shall be ignored: no latch, no queueing, current frame unaffected.
REQ-022 tx_data changes after the accept edge shall not affect the frame in progress.
REQ-023 Total frame length:
- (1+8+STOP_BITS)*CLKS_PER_BIT cycles without PARITY_EN.
- (2+8+STOP_BITS)*CLKS_PER_BIT cycles with PARITY_EN.

Reset
REQ-024 While rst=1 at a posedge, the block shall reset regardless of state (mid-frame included):
- FSM -> IDLE; baud counter, bit index, shift register -> 0.
- txd=1, tx_ready=1, busy=0, done=0.
REQ-025 A frame aborted by reset shall not produce done.
REQ-026 tx_valid in the reset cycle shall not be accepted.

Configuration
REQ-027 Macro UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 latched data bits) is sent between the last data bit and stop.
- Undefined: the PARITY state and the parity logic are absent, and the FSM goes DATA->STOP.

Structure
REQ-028 Package uart_pkg shall hold:
- The FSM state typedef.
- The data-width constant DATA_BITS=8.
- The idle/mark level constant.
- These are shared with the receive side.
REQ-029 One sub-module uart_baud_cnt shall be used.
- Ports: clk, rst, clear, tick.
- tick = one-cycle pulse at counter value CLKS_PER_BIT-1.
- uart_tx instantiates it once; no other sub-modules.

Verification (CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
REQ-030 Single byte, no parity: accept 8'hA5 at cycle 0.
- txd over cycles 1..40 = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
- done pulses at cycle 41; tx_ready=1 at cycle 41.
REQ-031 Parity: with UART_TX_PARITY_EN, 8'hA5 inserts parity 0 after the data bits; 8'h01 inserts parity 1.
- Frame length is 44 cycles.
REQ-032 Back-to-back: tx_valid held high with 8'h3C then 8'hC3.
- Two frames are sent with exactly one mark cycle between them.
- Decoded bytes are 8'h3C then 8'hC3.
REQ-033 Busy ignore: pulse tx_valid with 8'hFF mid-frame of 8'h00.
- Only 8'h00 is sent; no second frame follows.
REQ-034 Reset mid-frame: assert rst during DATA bit 3.
- Next cycle: txd=1, tx_ready=1, busy=0.
- No done pulse.
- A new byte is accepted cleanly afterwards.
REQ-035 STOP_BITS=2, CLKS_PER_BIT=2, byte 8'h80: stop high for 4 cycles; frame length 22 cycles.
